// File: rtl/satelite_frame_sequencer_if.sv
// Link-session signal bundle between the WS2811 decoder / CRC4 datapath (master)
// and the frame sequencer (slave).
interface satelite_frame_sequencer_if #(
    parameter int CRC_WD = 4
);
    logic              active;
    logic              serialClk;
    logic [CRC_WD-1:0] rxCrcCalc;
    logic [CRC_WD-1:0] rxCrcShift;
    logic [3:0]        cmdBits;
    logic              crcRxReset;
    logic              crcTxReset;
    logic              crcRxFreeze;
    logic              crcTxFreeze;
    logic              shiftCrcTx;
    logic              crcRxErr;
    logic              frameDone;
    logic              cmdInverseCrc;
    logic              cmdEnable;
    logic              wdDisableActuators;

    modport master (
        output active, serialClk, rxCrcCalc, rxCrcShift, cmdBits,
        input  crcRxReset, crcTxReset, crcRxFreeze, crcTxFreeze, shiftCrcTx,
               crcRxErr, frameDone, cmdInverseCrc, cmdEnable, wdDisableActuators
    );

    modport slave (
        input  active, serialClk, rxCrcCalc, rxCrcShift, cmdBits,
        output crcRxReset, crcTxReset, crcRxFreeze, crcTxFreeze, shiftCrcTx,
               crcRxErr, frameDone, cmdInverseCrc, cmdEnable, wdDisableActuators
    );
endinterface

// File: rtl/satelite_frame_sequencer.sv
// genericIOSatelite link-session sequencer: bit counting, CRC phase control,
// CRC check, command latch and link watchdog.
module satelite_frame_sequencer #(
    parameter int FRAME_BITS           = 64,
    parameter int CRC_WD               = 4,
    parameter int WATCHDOG_TIMEOUT_CYC = 10000000
) (
    input  logic                         masterClk,
    input  logic                         nReset,
    satelite_frame_sequencer_if.slave    link
);
    localparam int CNT_W = $clog2(FRAME_BITS + 1);
    localparam int WD_W  = $clog2(WATCHDOG_TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] C_FULL = CNT_W'(FRAME_BITS);
    localparam logic [CNT_W-1:0] C_CRC  = CNT_W'(CRC_WD);
    localparam logic [WD_W-1:0]  C_WD   = WD_W'(WATCHDOG_TIMEOUT_CYC);

    typedef enum logic [2:0] {S_IDLE, S_PAYLOAD, S_CRC, S_CHECK, S_LATCH} state_t;

    state_t           r_state, w_stateNxt;
    logic             r_prevSerialClk, r_prevActive;
    logic [CNT_W-1:0] r_bitCnt, w_bitCntNxt, w_bitCntDec;
    logic [WD_W-1:0]  r_wdCnt;
    logic             r_crcReset, w_crcResetNxt;
    logic             r_freeze, w_freezeNxt;
    logic             r_shiftCrcTx, w_shiftCrcTxNxt;
    logic             r_crcRxErr, w_crcRxErrNxt;
    logic             r_frameDone, w_frameDoneNxt;
    logic             r_cmdInverseCrc, w_cmdInverseCrcNxt;
    logic             r_cmdEnable, w_cmdEnableNxt;
    logic             r_wdDisable;
    logic             w_bitEdge, w_actRise, w_startFrame;
    logic             w_unusedCmd;

    assign w_bitEdge   = link.serialClk & ~r_prevSerialClk & link.active;
    assign w_actRise   = link.active & ~r_prevActive;
    assign w_bitCntDec = r_bitCnt - CNT_W'(1);
    assign w_unusedCmd = link.cmdBits[3] ^ link.cmdBits[0];
    // Starting from LATCH as well keeps a session whose rising edge coincides with LATCH.
    assign w_startFrame = ((r_state == S_IDLE) && w_actRise) ||
                          (((r_state == S_CHECK) || (r_state == S_LATCH)) && link.active);

    always_ff @(posedge masterClk or negedge nReset) begin
        if (!nReset) r_state <= S_IDLE;
        else         r_state <= w_stateNxt;
    end

    always_comb begin
        w_stateNxt = r_state;
        unique case (r_state)
            S_IDLE:    if (w_actRise) w_stateNxt = S_PAYLOAD;
            S_PAYLOAD: begin
                if (!link.active) w_stateNxt = S_LATCH;
                else if (w_bitEdge && (w_bitCntDec == C_CRC)) w_stateNxt = S_CRC;
            end
            S_CRC: begin
                if (!link.active) w_stateNxt = S_LATCH;
                else if (w_bitEdge && (w_bitCntDec == '0)) w_stateNxt = S_CHECK;
            end
            S_CHECK:   w_stateNxt = link.active ? S_PAYLOAD : S_LATCH;
            S_LATCH:   w_stateNxt = link.active ? S_PAYLOAD : S_IDLE;
            default:   w_stateNxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_bitCntNxt        = r_bitCnt;
        w_crcResetNxt      = 1'b0;
        w_freezeNxt        = r_freeze;
        w_shiftCrcTxNxt    = r_shiftCrcTx;
        w_crcRxErrNxt      = r_crcRxErr;
        w_frameDoneNxt     = 1'b0;
        w_cmdInverseCrcNxt = r_cmdInverseCrc;
        w_cmdEnableNxt     = r_cmdEnable;
        unique case (r_state)
            S_PAYLOAD: begin
                if (!link.active) begin
                    if (r_bitCnt != C_FULL) w_crcRxErrNxt = 1'b1;
                    w_shiftCrcTxNxt = 1'b0;
                end else if (w_bitEdge) begin
                    w_bitCntNxt = w_bitCntDec;
                    if (w_bitCntDec == C_CRC) begin
                        w_freezeNxt     = 1'b1;
                        w_shiftCrcTxNxt = 1'b1;
                    end
                end
            end
            S_CRC: begin
                if (!link.active) begin
                    w_crcRxErrNxt   = 1'b1;
                    w_shiftCrcTxNxt = 1'b0;
                end else if (w_bitEdge) begin
                    w_bitCntNxt = w_bitCntDec;
                    if (w_bitCntDec == '0) w_frameDoneNxt = 1'b1;
                end
            end
            S_CHECK: begin
                w_crcRxErrNxt   = (link.rxCrcCalc != link.rxCrcShift);
                w_shiftCrcTxNxt = 1'b0;
            end
            S_LATCH: begin
                if (!r_crcRxErr) begin
                    w_cmdInverseCrcNxt = link.cmdBits[1];
                    w_cmdEnableNxt     = link.cmdBits[2];
                end else begin
                    w_cmdInverseCrcNxt = 1'b0;
                end
            end
            default: ;
        endcase
        if (w_startFrame) begin
            w_bitCntNxt     = C_FULL;
            w_crcResetNxt   = 1'b1;
            w_freezeNxt     = 1'b0;
            w_shiftCrcTxNxt = 1'b0;
        end
    end

    always_ff @(posedge masterClk or negedge nReset) begin
        if (!nReset) begin
            r_prevSerialClk <= 1'b0;
            r_prevActive    <= 1'b0;
            r_bitCnt        <= C_FULL;
            r_crcReset      <= 1'b0;
            r_freeze        <= 1'b0;
            r_shiftCrcTx    <= 1'b0;
            r_crcRxErr      <= 1'b0;
            r_frameDone     <= 1'b0;
            r_cmdInverseCrc <= 1'b0;
            r_cmdEnable     <= 1'b0;
        end else begin
            r_prevSerialClk <= link.serialClk;
            r_prevActive    <= link.active;
            r_bitCnt        <= w_bitCntNxt;
            r_crcReset      <= w_crcResetNxt;
            r_freeze        <= w_freezeNxt;
            r_shiftCrcTx    <= w_shiftCrcTxNxt;
            r_crcRxErr      <= w_crcRxErrNxt;
            r_frameDone     <= w_frameDoneNxt;
            r_cmdInverseCrc <= w_cmdInverseCrcNxt;
            r_cmdEnable     <= w_cmdEnableNxt;
        end
    end

    // Flag rises together with the counter reaching the timeout, so it lands exactly TIMEOUT cycles after the clear.
    always_ff @(posedge masterClk or negedge nReset) begin
        if (!nReset) begin
            r_wdCnt     <= '0;
            r_wdDisable <= 1'b1;
        end else if (w_actRise) begin
            r_wdCnt     <= '0;
            r_wdDisable <= 1'b0;
        end else begin
            if (r_wdCnt != C_WD) r_wdCnt <= r_wdCnt + WD_W'(1);
            if (r_wdCnt >= C_WD - WD_W'(1)) r_wdDisable <= 1'b1;
        end
    end

    assign link.crcRxReset         = r_crcReset;
    assign link.crcTxReset         = r_crcReset;
    assign link.crcRxFreeze        = r_freeze;
    assign link.crcTxFreeze        = r_freeze;
    assign link.shiftCrcTx         = r_shiftCrcTx;
    assign link.crcRxErr           = r_crcRxErr;
    assign link.frameDone          = r_frameDone;
    assign link.cmdInverseCrc      = r_cmdInverseCrc;
    assign link.cmdEnable          = r_cmdEnable;
    assign link.wdDisableActuators = r_wdDisable;
endmodule

// File: tb/tb_satelite_frame_sequencer.sv
// Scoreboard bench: session-level reference model feeds expected CRC results to a
// frameDone monitor; per-edge and per-session checks run from the stimulus.
module tb_satelite_frame_sequencer;
    localparam int FB  = 64;
    localparam int CW  = 4;
    localparam int WDT = 100;

    logic masterClk = 1'b0;
    logic nReset    = 1'b0;
    always #5 masterClk = ~masterClk;

    satelite_frame_sequencer_if #(.CRC_WD(CW)) bus ();

    satelite_frame_sequencer #(
        .FRAME_BITS(FB),
        .CRC_WD(CW),
        .WATCHDOG_TIMEOUT_CYC(WDT)
    ) dut (
        .masterClk(masterClk),
        .nReset(nReset),
        .link(bus)
    );

    int   nvec = 0;
    int   nerr = 0;
    logic exp_err_q[$];
    int   frames_seen = 0, rst_pulses = 0, txrst_pulses = 0;
    int   exp_frames = 0, exp_resets = 0;
    logic m_err = 1'b0, m_inv = 1'b0, m_en = 1'b0;
    logic mon_pend = 1'b0, mon_exp = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge masterClk);
        #1;
    endtask

    // Monitor: compares crcRxErr the cycle after each frameDone; counts reset pulses.
    initial begin
        forever begin
            @(negedge masterClk);
            if (nReset) begin
                if (mon_pend) begin
                    chk("crcRxErr_after_frame", 32'(bus.crcRxErr), 32'(mon_exp));
                    mon_pend = 1'b0;
                end
                if (bus.crcRxReset === 1'b1) rst_pulses++;
                if (bus.crcTxReset === 1'b1) txrst_pulses++;
                if (bus.frameDone === 1'b1) begin
                    frames_seen++;
                    chk("frameDone_expected", 32'(exp_err_q.size() != 0), 32'(1));
                    if (exp_err_q.size() != 0) begin
                        mon_exp  = exp_err_q.pop_front();
                        mon_pend = 1'b1;
                    end
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic session(input int n, input logic [3:0] cmd, input bit rnd,
                           input logic [3:0] c, input logic [3:0] s);
        int   idx;
        logic e;
        logic last_err;
        last_err = 1'b0;
        bus.cmdBits = cmd;
        bus.active  = 1'b1;
        tick();
        exp_resets++;
        chk("wd_cleared_on_start", 32'(bus.wdDisableActuators), 32'(0));
        chk("crcRxReset_at_start", 32'(bus.crcRxReset), 32'(1));
        repeat ($urandom_range(0, 2)) tick();
        for (int i = 1; i <= n; i++) begin
            idx = (i - 1) % FB + 1;
            if (idx == 1) begin
                if (rnd) begin
                    bus.rxCrcCalc  = 4'($urandom);
                    bus.rxCrcShift = ($urandom_range(0, 1) == 1) ? bus.rxCrcCalc : 4'($urandom);
                end else begin
                    bus.rxCrcCalc  = c;
                    bus.rxCrcShift = s;
                end
            end
            if (idx == FB) begin
                last_err = (bus.rxCrcCalc != bus.rxCrcShift);
                exp_err_q.push_back(last_err);
                exp_frames++;
                if (i != n) exp_resets++;
            end
            bus.serialClk = 1'b1;
            tick();
            if (idx != FB) begin
                e = (idx >= FB - CW);
                chk("shift_and_freeze", 32'({bus.shiftCrcTx, bus.crcRxFreeze, bus.crcTxFreeze}),
                    32'({e, e, e}));
            end
            bus.serialClk = 1'b0;
            if (i != n) repeat ($urandom_range(1, 3)) tick();
        end
        bus.active = 1'b0;
        if (n % FB != 0)  m_err = 1'b1;
        else if (n > 0)   m_err = last_err;
        if (!m_err) begin
            m_inv = cmd[1];
            m_en  = cmd[2];
        end else begin
            m_inv = 1'b0;
        end
        repeat (4) tick();
        chk("crcRxErr_session", 32'(bus.crcRxErr), 32'(m_err));
        chk("cmdInverseCrc", 32'(bus.cmdInverseCrc), 32'(m_inv));
        chk("cmdEnable", 32'(bus.cmdEnable), 32'(m_en));
        chk("idle_shift_done", 32'({bus.shiftCrcTx, bus.frameDone}), 32'(0));
    endtask

    initial begin
        int n, r;
        bus.active     = 1'b0;
        bus.serialClk  = 1'b0;
        bus.rxCrcCalc  = '0;
        bus.rxCrcShift = '0;
        bus.cmdBits    = '0;
        repeat (3) tick();
        chk("reset_wd", 32'(bus.wdDisableActuators), 32'(1));
        chk("reset_outs", 32'({bus.shiftCrcTx, bus.crcRxErr, bus.frameDone, bus.crcRxReset,
                               bus.cmdInverseCrc, bus.cmdEnable, bus.crcRxFreeze}), 32'(0));
        nReset = 1'b1;
        tick();

        session(64, 4'b0110, 1'b0, 4'hA, 4'hA);
        session(64, 4'b0010, 1'b0, 4'hA, 4'h5);
        session(30, 4'($urandom), 1'b0, 4'hA, 4'hA);
        session(128, 4'b0110, 1'b0, 4'h3, 4'h3);

        bus.active = 1'b1;
        tick();
        exp_resets++;
        chk("wd_clear", 32'(bus.wdDisableActuators), 32'(0));
        bus.active = 1'b0;
        if (!m_err) begin
            m_inv = bus.cmdBits[1];
            m_en  = bus.cmdBits[2];
        end else m_inv = 1'b0;
        repeat (WDT - 1) tick();
        chk("wd_before_timeout", 32'(bus.wdDisableActuators), 32'(0));
        tick();
        chk("wd_at_timeout", 32'(bus.wdDisableActuators), 32'(1));
        chk("cmd_after_empty_session", 32'({bus.cmdInverseCrc, bus.cmdEnable}), 32'({m_inv, m_en}));

        repeat (12) begin
            r = $urandom_range(0, 4);
            n = (r == 0) ? 0 : (r == 1) ? FB : (r == 2) ? 2 * FB : $urandom_range(1, 3 * FB - 1);
            session(n, 4'($urandom), 1'b1, 4'h0, 4'h0);
        end

        session(64, 4'b0110, 1'b0, 4'h1, 4'h1);
        session(64, 4'b0110, 1'b0, 4'h1, 4'h2);
        bus.active = 1'b1;
        tick();
        exp_resets++;
        for (int i = 0; i < FB - 2; i++) begin
            bus.serialClk = 1'b1;
            tick();
            bus.serialClk = 1'b0;
            tick();
        end
        chk("shift_before_reset", 32'(bus.shiftCrcTx), 32'(1));
        bus.active = 1'b0;
        nReset = 1'b0;
        #2;
        chk("midrun_reset_wd", 32'(bus.wdDisableActuators), 32'(1));
        chk("midrun_reset_outs", 32'({bus.shiftCrcTx, bus.crcRxErr, bus.frameDone, bus.crcRxReset,
                                      bus.cmdInverseCrc, bus.cmdEnable, bus.crcRxFreeze}), 32'(0));
        tick();
        nReset = 1'b1;
        m_err = 1'b0;
        m_inv = 1'b0;
        m_en  = 1'b0;
        tick();
        session(64, 4'b0100, 1'b0, 4'h7, 4'h7);

        repeat (3) tick();
        chk("queue_empty", 32'(exp_err_q.size()), 32'(0));
        chk("frame_count", 32'(frames_seen), 32'(exp_frames));
        chk("crcRxReset_pulses", 32'(rst_pulses), 32'(exp_resets));
        chk("crcTxReset_pulses", 32'(txrst_pulses), 32'(exp_resets));
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
